addsub_pipe: RTL and testbench
==============================

Name: addsub_pipe

Overview:
- Parametrised, pipelined add/subtract unit; next generation of the fixed-function 8-bit adder/subtractor blocks.
- Generalises operand width, adds run-time operation select, valid/ready flow control with backpressure, and a signed-overflow flag.
- Sits between operand producers and the result consumer in the datapath. Three-stage register pipeline: operand, compute, output.

Parameters:
- WIDTH, 8, operand width in bits (min 2).
- OP_MODE, 2, 0 = add only, 1 = subtract only, 2 = run-time select via op_sel. A generate-if selects the datapath.
- OUT_REG, 1, 1 = registered output stage (latency 3); 0 = output taken from the compute stage (latency 2).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  unit can accept a beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op_sel  in  1  0 = A+B, 1 = A-B; sampled with the beat; ignored unless OP_MODE=2
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts the result
- result  out  WIDTH+1  {carry|borrow, WIDTH-bit sum/difference}
- ovf  out  1  signed two's-complement overflow of the WIDTH-bit result

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: every stage valid bit = 0; out_valid = 0; result = 0; ovf = 0; data registers = 0.
- Reset asserted mid-operation flushes all in-flight beats. No beat issues in the cycle after reset deasserts unless it was accepted on that edge.
- Stage valids: v1 (operand), v2 (compute), v3 (output, present only if OUT_REG=1).
- Pipeline advance: global enable en = !out_valid || out_ready.
  - in_ready = en; this is a combinational path from out_ready.
  - Transfer occurs on in_valid && in_ready.
  - On en, all stages shift: v1 <= in_valid, v2 <= v1, v3 <= v2.
  - Data registers load only when the incoming stage valid is 1, to limit toggling.
  - When en = 0, every register holds, and a/b/op_sel are not sampled.
- Latency:
  - Accepted beat appears on out_valid exactly 3 cycles later (2 if OUT_REG=0) with no stall.
  - Each stall cycle adds one cycle.
  - Throughput is 1 beat/cycle with out_ready held high.
- Arithmetic (compute stage):
  - ADD: result = {1'b0,a} + {1'b0,b}; result[WIDTH] = carry out.
  - SUB: result = {1'b0,a} - {1'b0,b} mod 2^(WIDTH+1); result[WIDTH] = 1 when a < b (unsigned borrow).
  - ovf, ADD: a, b same sign and sum sign differs.
  - ovf, SUB: a, b signs differ and difference sign differs from a.
- OP_MODE 0/1: op_sel has no effect; the unused datapath is not generated.
- Bubbles (v = 0) never produce out_valid.
- result and ovf hold their last values while out_valid = 0. Bench checks them only when out_valid = 1.
- Data ordering is strictly FIFO. No beat is dropped or duplicated under any out_ready pattern.

Decomposition:
- Shared package addsub_pkg:
  - OP_ADD = 1'b0, OP_SUB = 1'b1.
  - OP_MODE encodings MODE_ADD = 0, MODE_SUB = 1, MODE_RUNTIME = 2.
- Sub-module addsub_core: combinational WIDTH-generic add/sub with carry/borrow and ovf.
  - Contains the generate-if over OP_MODE.
  - Instantiated once in the compute stage. Pipeline and handshake stay in addsub_pipe.

Test Plan:
- Reset and latency: WIDTH=8, OP_MODE=2, out_ready=1. Assert rst 2 cycles, then one beat a=8'h05, b=8'h03, op_sel=0. Required: out_valid high exactly 3 cycles after acceptance; result=9'h008; ovf=0. out_valid=0 during and after reset.
- Carry and overflow:
  - Add a=8'hFF, b=8'h01 -> result=9'h100, ovf=0.
  - Add a=8'h7F, b=8'h01 -> result=9'h080, ovf=1.
- Borrow:
  - Sub a=8'h03, b=8'h05 -> result=9'h1FE, ovf=0.
  - Sub a=8'h80, b=8'h01 -> result=9'h07F, ovf=1.
- Backpressure: stream 10 beats, a=i, b=1, alternating op_sel. Pattern out_ready 1,0,0,1,0,1... Required: in_ready == (!out_valid || out_ready) every cycle; results are i+1 and i-1 in order with no loss or duplication.
- Mid-stream reset: 3 beats in flight, assert rst for 1 cycle. Required: out_valid=0 the cycle after, none of the 3 beats ever emerges, and a fresh beat afterwards has normal latency.
- Fixed modes:
  - OP_MODE=1, op_sel toggling randomly, a=8'h10, b=8'h20 -> result=9'h1F0 every beat.
  - OP_MODE=0, OUT_REG=0 -> latency 2; a=8'h10, b=8'h20 gives result=9'h030.

Source files
------------

// File: rtl/addsub_pkg.sv
// addsub_pkg
// Shared constants for the add/subtract pipeline:
//   OP_ADD / OP_SUB    - encoding of the run-time op_sel input
//   MODE_ADD / MODE_SUB / MODE_RUNTIME - encoding of the OP_MODE parameter
package addsub_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   localparam int MODE_ADD     = 0;
   localparam int MODE_SUB     = 1;
   localparam int MODE_RUNTIME = 2;

endpackage : addsub_pkg

// File: rtl/addsub_core.sv
// addsub_core
// Combinational WIDTH-generic adder/subtractor with carry/borrow and signed
// overflow. Only the datapath selected by OP_MODE is built.
// Ports:
//   a_i, b_i   [WIDTH-1:0]  operands
//   op_sel_i                0 = add, 1 = subtract (used only when OP_MODE is run-time)
//   result_o   [WIDTH:0]    {carry|borrow, WIDTH-bit sum/difference}
//   ovf_o                   two's-complement overflow of the WIDTH-bit result
module addsub_core
   import addsub_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int OP_MODE = MODE_RUNTIME
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             op_sel_i,
   output logic [WIDTH:0]   result_o,
   output logic             ovf_o
);

   // Arguments are the sign bits of a, b and the WIDTH-bit result.
   function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
      return (sa == sb) && (sr != sa);
   endfunction

   function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
      return (sa != sb) && (sr != sa);
   endfunction

   logic signed [WIDTH-1:0] a_s;
   logic signed [WIDTH-1:0] b_s;

   assign a_s = $signed(a_i);
   assign b_s = $signed(b_i);

   generate
      if (OP_MODE == MODE_ADD) begin : g_add
         logic [WIDTH:0] sum;
         logic           unused_op;

         assign sum       = {1'b0, a_i} + {1'b0, b_i};
         assign result_o  = sum;
         assign ovf_o     = add_ovf(a_s[WIDTH-1], b_s[WIDTH-1], sum[WIDTH-1]);
         assign unused_op = op_sel_i;
      end else if (OP_MODE == MODE_SUB) begin : g_sub
         logic [WIDTH:0] dif;
         logic           unused_op;

         // MSB of the (WIDTH+1)-bit difference is the unsigned borrow (a < b).
         assign dif       = {1'b0, a_i} - {1'b0, b_i};
         assign result_o  = dif;
         assign ovf_o     = sub_ovf(a_s[WIDTH-1], b_s[WIDTH-1], dif[WIDTH-1]);
         assign unused_op = op_sel_i;
      end else begin : g_runtime
         logic [WIDTH:0] sum;
         logic [WIDTH:0] dif;

         assign sum      = {1'b0, a_i} + {1'b0, b_i};
         assign dif      = {1'b0, a_i} - {1'b0, b_i};
         assign result_o = (op_sel_i == OP_ADD) ? sum : dif;
         assign ovf_o    = (op_sel_i == OP_ADD)
                           ? add_ovf(a_s[WIDTH-1], b_s[WIDTH-1], sum[WIDTH-1])
                           : sub_ovf(a_s[WIDTH-1], b_s[WIDTH-1], dif[WIDTH-1]);
      end
   endgenerate

endmodule : addsub_core

// File: rtl/addsub_pipe.sv
// addsub_pipe
// Pipelined add/subtract unit with valid/ready flow control.
// Stages: operand (p0) -> compute (p1) -> optional output register (p2).
// The whole pipeline advances on one global enable, so a stalled consumer
// freezes every stage and in_ready follows out_ready combinationally.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid / in_ready    operand handshake
//   a, b     [WIDTH-1:0]   operands
//   op_sel                 0 = A+B, 1 = A-B (run-time mode only)
//   out_valid / out_ready  result handshake
//   result   [WIDTH:0]     {carry|borrow, sum/difference}
//   ovf                    signed overflow of the WIDTH-bit result
module addsub_pipe
   import addsub_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int OP_MODE = MODE_RUNTIME,
   parameter int OUT_REG = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op_sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   result,
   output logic             ovf
);

   logic             en;

   logic             vld_p0_q;
   logic [WIDTH-1:0] a_p0_q;
   logic [WIDTH-1:0] b_p0_q;
   logic             op_p0_q;

   logic             vld_p1_q;
   logic [WIDTH:0]   res_p1_d;
   logic             ovf_p1_d;
   logic [WIDTH:0]   res_p1_q;
   logic             ovf_p1_q;

   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   // ---- stage p0: operand capture ----
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0_q <= 1'b0;
         a_p0_q   <= '0;
         b_p0_q   <= '0;
         op_p0_q  <= 1'b0;
      end else if (en) begin
         vld_p0_q <= in_valid;
         if (in_valid) begin
            a_p0_q  <= a;
            b_p0_q  <= b;
            op_p0_q <= op_sel;
         end
      end
   end

   addsub_core #(
      .WIDTH   (WIDTH),
      .OP_MODE (OP_MODE)
   ) u_core (
      .a_i      (a_p0_q),
      .b_i      (b_p0_q),
      .op_sel_i (op_p0_q),
      .result_o (res_p1_d),
      .ovf_o    (ovf_p1_d)
   );

   // ---- stage p1: compute ----
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1_q <= 1'b0;
         res_p1_q <= '0;
         ovf_p1_q <= 1'b0;
      end else if (en) begin
         vld_p1_q <= vld_p0_q;
         if (vld_p0_q) begin
            res_p1_q <= res_p1_d;
            ovf_p1_q <= ovf_p1_d;
         end
      end
   end

   // ---- stage p2: output register (optional) ----
   generate
      if (OUT_REG != 0) begin : g_oreg
         logic           vld_p2_q;
         logic [WIDTH:0] res_p2_q;
         logic           ovf_p2_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               vld_p2_q <= 1'b0;
               res_p2_q <= '0;
               ovf_p2_q <= 1'b0;
            end else if (en) begin
               vld_p2_q <= vld_p1_q;
               if (vld_p1_q) begin
                  res_p2_q <= res_p1_q;
                  ovf_p2_q <= ovf_p1_q;
               end
            end
         end

         assign out_valid = vld_p2_q;
         assign result    = res_p2_q;
         assign ovf       = ovf_p2_q;
      end else begin : g_noreg
         assign out_valid = vld_p1_q;
         assign result    = res_p1_q;
         assign ovf       = ovf_p1_q;
      end
   endgenerate

endmodule : addsub_pipe

// File: tb/tb_addsub_pipe.sv
// Testbench for addsub_pipe. Three instances share stimulus:
//   dut 0: OP_MODE=2 (run-time), OUT_REG=1
//   dut 1: OP_MODE=1 (subtract), OUT_REG=1
//   dut 2: OP_MODE=0 (add),      OUT_REG=0
// Each instance tracks its own acceptances; a scoreboard queue holds the
// expected responses and a negedge monitor pops and compares them.
module tb_addsub_pipe;

   localparam int W = 8;

   typedef struct {
      int         id;
      logic [W:0] res;
      logic       ovf;
      int         acc;
      int         snap;
   } exp_t;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         op_sel;
   logic         out_ready;

   logic [2:0]   in_ready_w;
   logic [2:0]   out_valid_w;
   logic [2:0]   ovf_w;
   logic [W:0]   result_w [3];

   exp_t         sbq[$];
   int           stalls [3];
   int           cyc;
   logic         rst_prev;
   int           bp_mode;
   int           checks;
   int           errors;

   addsub_pipe #(.WIDTH(W), .OP_MODE(2), .OUT_REG(1)) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
      .a(a), .b(b), .op_sel(op_sel), .out_valid(out_valid_w[0]),
      .out_ready(out_ready), .result(result_w[0]), .ovf(ovf_w[0])
   );

   addsub_pipe #(.WIDTH(W), .OP_MODE(1), .OUT_REG(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
      .a(a), .b(b), .op_sel(op_sel), .out_valid(out_valid_w[1]),
      .out_ready(out_ready), .result(result_w[1]), .ovf(ovf_w[1])
   );

   addsub_pipe #(.WIDTH(W), .OP_MODE(0), .OUT_REG(0)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[2]),
      .a(a), .b(b), .op_sel(op_sel), .out_valid(out_valid_w[2]),
      .out_ready(out_ready), .result(result_w[2]), .ovf(ovf_w[2])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int mode_of(input int k);
      return (k == 0) ? 2 : ((k == 1) ? 1 : 0);
   endfunction

   function automatic int lat_of(input int k);
      return (k == 2) ? 2 : 3;
   endfunction

   // Reference: plain integer arithmetic, result mod 2^(W+1), overflow when
   // the signed result leaves [-128, 127]. Returns {ovf, result}.
   function automatic logic [W+1:0] model(input int mode, input logic op,
                                          input logic [W-1:0] ta, input logic [W-1:0] tb);
      int   ua;
      int   ub;
      int   sa;
      int   sb;
      int   r;
      int   s;
      logic do_sub;
      ua = int'(ta);
      ub = int'(tb);
      sa = (ua >= 128) ? ua - 256 : ua;
      sb = (ub >= 128) ? ub - 256 : ub;
      do_sub = (mode == 1) || (mode == 2 && op);
      if (do_sub) begin
         r = ua - ub;
         s = sa - sb;
      end else begin
         r = ua + ub;
         s = sa + sb;
      end
      r = r & 511;
      return {(s > 127 || s < -128), r[W:0]};
   endfunction

   // Acceptance tracker: pushes an expectation for every beat each instance
   // takes; reset discards everything in flight.
   initial begin
      exp_t         e;
      logic [W+1:0] m;
      rst_prev = 1'b0;
      cyc      = 0;
      forever begin
         @(posedge clk);
         for (int k = 0; k < 3; k++)
            if (out_valid_w[k] && !out_ready) stalls[k]++;
         if (rst) begin
            sbq.delete();
         end else begin
            for (int k = 0; k < 3; k++) begin
               if (in_valid && in_ready_w[k]) begin
                  m      = model(mode_of(k), op_sel, a, b);
                  e.id   = k;
                  e.res  = m[W:0];
                  e.ovf  = m[W+1];
                  e.acc  = cyc;
                  e.snap = stalls[k];
                  sbq.push_back(e);
               end
            end
         end
         rst_prev = rst;
         cyc++;
      end
   end

   // Monitor
   initial begin
      exp_t e;
      int   idx;
      int   exp_cyc;
      forever begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (in_ready_w[k] !== (!out_valid_w[k] || out_ready)) begin
               errors++;
               $display("FAIL dut%0d in_ready: got %b required %b", k, in_ready_w[k],
                        (!out_valid_w[k] || out_ready));
            end
            if (rst_prev) begin
               checks++;
               if (out_valid_w[k] !== 1'b0) begin
                  errors++;
                  $display("FAIL dut%0d out_valid_after_reset: got %b required 0", k, out_valid_w[k]);
               end
            end
            if (!rst && out_valid_w[k] && out_ready) begin
               idx = -1;
               for (int i = 0; i < sbq.size(); i++) begin
                  if (sbq[i].id == k) begin
                     idx = i;
                     break;
                  end
               end
               if (idx < 0) begin
                  checks++;
                  errors++;
                  $display("FAIL dut%0d spurious_beat: got result %h with nothing expected", k, result_w[k]);
               end else begin
                  e = sbq[idx];
                  sbq.delete(idx);
                  exp_cyc = e.acc + lat_of(k) + (stalls[k] - e.snap);
                  checks += 3;
                  if (result_w[k] !== e.res) begin
                     errors++;
                     $display("FAIL dut%0d result: got %h required %h", k, result_w[k], e.res);
                  end
                  if (ovf_w[k] !== e.ovf) begin
                     errors++;
                     $display("FAIL dut%0d ovf: got %b required %b (result %h)", k, ovf_w[k], e.ovf, e.res);
                  end
                  if (cyc != exp_cyc) begin
                     errors++;
                     $display("FAIL dut%0d latency: got cycle %0d required cycle %0d", k, cyc, exp_cyc);
                  end
               end
            end
         end
      end
   end

   // out_ready driver: 0 = always 1, 1 = 1,0,0,1,0,1 pattern, 2 = random, 3 = held 0
   initial begin
      int pi;
      int pat [6];
      pat = '{1, 0, 0, 1, 0, 1};
      pi = 0;
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (bp_mode)
            1: begin
               out_ready = (pat[pi] != 0);
               pi = (pi + 1) % 6;
            end
            2:       out_ready = 1'($urandom_range(0, 1));
            3:       out_ready = 1'b0;
            default: out_ready = 1'b1;
         endcase
      end
   end

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic top);
      int   n;
      logic ok;
      n        = 0;
      ok       = 1'b0;
      a        = ta;
      b        = tb;
      op_sel   = top;
      in_valid = 1'b1;
      while (!ok && n < 200) begin
         @(negedge clk);
         ok = in_ready_w[0];
         @(posedge clk);
         #1;
         n++;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n        = 0;
      in_valid = 1'b0;
      while (sbq.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      #1;
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d beats outstanding, required 0", sbq.size());
      end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1, "timeout");
   end

   initial begin
      checks   = 0;
      errors   = 0;
      bp_mode  = 0;
      rst      = 1'b1;
      in_valid = 1'b0;
      a        = '0;
      b        = '0;
      op_sel   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         checks += 3;
         if (out_valid_w[k] !== 1'b0) begin
            errors++;
            $display("FAIL dut%0d reset_out_valid: got %b required 0", k, out_valid_w[k]);
         end
         if (result_w[k] !== '0) begin
            errors++;
            $display("FAIL dut%0d reset_result: got %h required 000", k, result_w[k]);
         end
         if (ovf_w[k] !== 1'b0) begin
            errors++;
            $display("FAIL dut%0d reset_ovf: got %b required 0", k, ovf_w[k]);
         end
      end
      rst = 1'b0;

      // Single beat after reset, then carry / overflow / borrow corners.
      send(8'h05, 8'h03, 1'b0);
      idle(5);
      send(8'hFF, 8'h01, 1'b0);
      send(8'h7F, 8'h01, 1'b0);
      send(8'h03, 8'h05, 1'b1);
      send(8'h80, 8'h01, 1'b1);
      repeat (4) send(8'h10, 8'h20, 1'($urandom_range(0, 1)));
      idle(5);
      wait_drain();

      // Backpressure stream.
      bp_mode = 1;
      for (int i = 0; i < 10; i++) send(8'(i), 8'h01, 1'(i % 2));
      wait_drain();

      // Mid-stream reset with three beats held in flight.
      bp_mode = 3;
      idle(2);
      for (int i = 0; i < 3; i++) send(8'(8'h40 + i), 8'h02, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst     = 1'b0;
      bp_mode = 0;
      idle(3);
      send(8'h21, 8'h12, 1'b1);
      idle(6);
      wait_drain();

      // Random operands under random backpressure.
      bp_mode = 2;
      for (int i = 0; i < 80; i++) begin
         send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
      bp_mode = 0;
      wait_drain();
      idle(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_addsub_pipe
